// File: rtl/bd_pkg.sv
// Shared types and constants for the bundled-data receive path.
//
// Contents:
//   bd_rx_state_e    - receiver handshake FSM states (IDLE, ACK, STALL)
//   MIN_SYNC_STAGES  - smallest synchronizer depth considered metastability-safe
//   BD_DEFAULT_DATA_W, bd_word_t - default bundled word type; modules with a
//                      configurable width declare their own word type from
//                      their DATA_W parameter.
package bd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        STALL = 2'd2
    } bd_rx_state_e;

    localparam int MIN_SYNC_STAGES   = 2;
    localparam int BD_DEFAULT_DATA_W = 16;

    typedef logic [BD_DEFAULT_DATA_W-1:0] bd_word_t;

endpackage

// File: rtl/bd_sync_ff.sv
// Single-bit multi-flop synchronizer for asynchronous control inputs.
//
// Parameters:
//   STAGES   - flop chain depth. Values below MIN_SYNC_STAGES are raised to it.
// Ports:
//   clk      - destination clock
//   rst_n    - asynchronous active-low reset; clears every stage to 0
//   i_async  - asynchronous level input
//   o_sync   - synchronized level (last stage of the chain)
module bd_sync_ff
    import bd_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    localparam int DEPTH = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [DEPTH-1:0] r_chain;

    // Bit 0 is the stage that samples the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], i_async};
        end
    end

    assign o_sync = r_chain[DEPTH-1];

endmodule

// File: rtl/bd_rx_sync.sv
// Clocked receiver for a 4-phase bundled-data channel.
//
// The asynchronous request is synchronized into the clk domain; the bundled
// data is captured directly (never synchronized) once the synchronized
// request is seen and the acknowledge is still low, which is when the
// bundling constraint guarantees it is stable. Captured words are buffered
// in a small FIFO presented downstream as a show-ahead valid/ready stream.
//
// Parameters:
//   DATA_W      - bundled-data width
//   SYNC_STAGES - request synchronizer depth (2..4)
//   FIFO_DEPTH  - buffer entries, power of 2, at least 2
// Ports:
//   clk         - clock
//   rst_n       - asynchronous active-low reset
//   bd_req      - asynchronous 4-phase request (level)
//   bd_data     - bundled data, stable while bd_req=1 and bd_ack=0
//   bd_ack      - registered acknowledge back to the transmitter
//   out_valid   - FIFO head is valid
//   out_data    - FIFO head (show-ahead)
//   out_ready   - consumer accepts the head
//   fifo_level  - current FIFO occupancy
module bd_rx_sync
    import bd_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bd_req,
    input  logic [DATA_W-1:0]             bd_data,
    output logic                          bd_ack,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef logic [DATA_W-1:0] rx_word_t;

    rx_word_t      r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    bd_rx_state_e  r_state;
    logic          r_ack;

    logic          w_req_s;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    bd_sync_ff #(
        .STAGES  (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bd_req),
        .o_sync  (w_req_s)
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the addresses match.
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_pop   = !w_empty && out_ready;

    // Push decision uses the current-cycle full flag only: a pop in the same
    // cycle does not open a slot until the following cycle.
    always_comb begin
        w_push = 1'b0;
        case (r_state)
            IDLE:    w_push = w_req_s && !w_full;
            STALL:   w_push = !w_full;
            default: w_push = 1'b0;
        endcase
    end

    // Handshake FSM. Exactly one push per 4-phase cycle: the push happens on
    // the transition into ACK, and ACK waits for the return-to-zero request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_s) begin
                        if (!w_full) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (!w_full) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end
                end
                ACK: begin
                    if (!w_req_s) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is data only; contents are meaningless until written, and the
    // empty flag masks them, so no reset is applied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bd_data;
        end
    end

    assign bd_ack     = r_ack;
    assign out_valid  = !w_empty;
    assign out_data   = r_mem[r_rd_ptr[AW-1:0]];
    // Modulo subtraction of the extended pointers yields 0..FIFO_DEPTH.
    assign fifo_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_bd_rx_sync.sv
module tb_bd_rx_sync;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bd_req;
    logic [DATA_W-1:0] bd_data;
    logic              bd_ack;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [2:0]        fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    bit                mon_en = 1'b0;
    logic [DATA_W-1:0] mon_q[$];
    int                max_level = 0;

    bd_rx_sync #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bd_req     (bd_req),
        .bd_data    (bd_data),
        .bd_ack     (bd_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Record every accepted word half a cycle before the edge that pops it.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) mon_q.push_back(out_data);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input logic val, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step(1);
            if (bd_ack === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input string tag);
        bit ok;
        bd_data = d;
        bd_req  = 1'b1;
        wait_ack(1'b1, 20, ok);
        chk({tag, "_ack_rise"}, 32'(ok), 32'd1);
        bd_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        chk({tag, "_ack_fall"}, 32'(ok), 32'd1);
    endtask

    task automatic pop_expect(input logic [DATA_W-1:0] d, input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        rst_n     = 1'b0;
        bd_req    = 1'b0;
        bd_data   = '0;
        out_ready = 1'b0;
        step(2);

        // Reset state
        chk("rst_ack",   32'(bd_ack),     32'd0);
        chk("rst_valid", 32'(out_valid),  32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Single token: ack exactly two edges after first sampling edge E
        bd_data = 16'hA5C3;
        bd_req  = 1'b1;
        step(1);                                    // E
        step(1);                                    // E+1
        chk("single_ack_early", 32'(bd_ack), 32'd0);
        step(1);                                    // E+2
        chk("single_ack",   32'(bd_ack),     32'd1);
        chk("single_valid", 32'(out_valid),  32'd1);
        chk("single_data",  32'(out_data),   32'h0000A5C3);
        chk("single_level", 32'(fifo_level), 32'd1);
        bd_req = 1'b0;
        step(2);                                    // E'+1
        chk("single_ack_hold", 32'(bd_ack), 32'd1);
        step(1);                                    // E'+2
        chk("single_ack_fall",   32'(bd_ack),     32'd0);
        chk("single_level_rtz",  32'(fifo_level), 32'd1);
        pop_expect(16'hA5C3, "single_pop");
        chk("single_empty", 32'(fifo_level), 32'd0);

        // Burst to full with consumer stalled
        for (int t = 1; t <= 4; t++) send(16'(t), "burst");
        chk("burst_level4", 32'(fifo_level), 32'd4);
        bd_data = 16'd5;
        bd_req  = 1'b1;
        step(6);
        chk("burst_stall_ack",   32'(bd_ack),     32'd0);
        chk("burst_stall_level", 32'(fifo_level), 32'd4);
        chk("burst_stall_head",  32'(out_data),   32'd1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("burst_pop_level", 32'(fifo_level), 32'd3);
        chk("burst_pop_ack",   32'(bd_ack),     32'd0);
        chk("burst_pop_head",  32'(out_data),   32'd2);
        step(1);
        chk("burst_tok5_ack",   32'(bd_ack),     32'd1);
        chk("burst_tok5_level", 32'(fifo_level), 32'd4);
        bd_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        chk("burst_tok5_fall", 32'(ok), 32'd1);
        for (int t = 2; t <= 5; t++) pop_expect(16'(t), "burst_drain");
        chk("burst_empty", 32'(out_valid), 32'd0);

        // Ordering and pointer wrap with a free-running consumer
        out_ready = 1'b1;
        max_level = 0;
        mon_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) send(16'(i), "wrap");
        step(3);
        mon_en    = 1'b0;
        out_ready = 1'b0;
        chk("wrap_count", 32'(mon_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < mon_q.size()) chk("wrap_order", 32'(mon_q[i]), 32'(i));
        end
        chk("wrap_max_level_ok", 32'(max_level <= 4), 32'd1);
        chk("wrap_empty", 32'(fifo_level), 32'd0);

        // Simultaneous push and pop at level 2
        send(16'h1111, "simul");
        send(16'h2222, "simul");
        chk("simul_level2", 32'(fifo_level), 32'd2);
        bd_data = 16'h3333;
        bd_req  = 1'b1;
        step(2);                                    // E, E+1
        out_ready = 1'b1;
        step(1);                                    // E+2: push and pop
        out_ready = 1'b0;
        chk("simul_ack",   32'(bd_ack),     32'd1);
        chk("simul_level", 32'(fifo_level), 32'd2);
        chk("simul_head",  32'(out_data),   32'h2222);
        bd_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        chk("simul_fall", 32'(ok), 32'd1);
        pop_expect(16'h2222, "simul_drain");
        pop_expect(16'h3333, "simul_drain");

        // Hold-off: long request high phase yields a single push
        bd_data = 16'hBEEF;
        bd_req  = 1'b1;
        wait_ack(1'b1, 20, ok);
        chk("hold_rise", 32'(ok), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("hold_ack", 32'(bd_ack), 32'd1);
        end
        chk("hold_level", 32'(fifo_level), 32'd1);
        bd_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        chk("hold_fall", 32'(ok), 32'd1);
        pop_expect(16'hBEEF, "hold_drain");
        chk("hold_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset in ACK state with three entries buffered
        send(16'h0101, "rst_mid");
        send(16'h0202, "rst_mid");
        bd_data = 16'h0303;
        bd_req  = 1'b1;
        wait_ack(1'b1, 20, ok);
        chk("rst_mid_rise",  32'(ok),         32'd1);
        chk("rst_mid_level", 32'(fifo_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack",   32'(bd_ack),     32'd0);
        chk("rst_mid_valid", 32'(out_valid),  32'd0);
        chk("rst_mid_lvl0",  32'(fifo_level), 32'd0);
        step(1);
        rst_n = 1'b1;
        wait_ack(1'b1, 20, ok);
        chk("rst_recap_rise",  32'(ok),         32'd1);
        chk("rst_recap_level", 32'(fifo_level), 32'd1);
        chk("rst_recap_data",  32'(out_data),   32'h0303);
        bd_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        chk("rst_recap_fall",  32'(ok),         32'd1);
        chk("rst_recap_lvl",   32'(fifo_level), 32'd1);
        pop_expect(16'h0303, "rst_recap_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
